// File: rtl/uart_port.sv
// Full-duplex UART endpoint: byte FIFOs toward the CPU side, configurable frame
// format and runtime baud divisor toward the pins, sticky receive error flags.
module uart_port_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a push on a full FIFO is accepted
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

module uart_port #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4,
  parameter int DIV_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             send_flag,
  input  logic [7:0]       send_data,
  output logic             sendable,
  input  logic             recv_flag,
  output logic [7:0]       recv_data,
  output logic             receivable,
  output logic             tx_busy,
  output logic             err_parity,
  output logic             err_frame,
  output logic             err_overrun,
  input  logic             err_clear,
  output logic             Tx,
  input  logic             Rx
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic ODD = (PARITY == 2);

  logic [DIV_W-1:0] div_c;
  assign div_c = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;

  logic unused_hi;
  assign unused_hi = ^send_data;

  // ---------------- transmit ----------------
  logic [DATA_BITS-1:0] tx_head, tx_sh, tx_sh_d;
  logic                 tx_empty, tx_full, tx_pop, tx_par, tx_par_d, tx_line;
  logic [DIV_W-1:0]     tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [3:0]           tx_bit, tx_bit_d;
  state_t               tx_state, tx_state_d;

  uart_port_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .CLK(CLK), .RST(RST), .push(send_flag), .din(send_data[DATA_BITS-1:0]),
    .pop(tx_pop), .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );
  assign sendable = !tx_full;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      Tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_div   <= tx_div_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx_par   <= tx_par_d;
      // the pin lags the state by one cycle, giving the FIFO-write/pop/start pipeline
      Tx       <= tx_line;
      tx_busy  <= (tx_state != S_IDLE);
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_div_d   = tx_div;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_par_d   = tx_par;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    case (tx_state)
      S_IDLE: tx_pop = !tx_empty;
      S_START: begin
        tx_line = 1'b0;
        if (tx_cnt == '0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = tx_div - DIV_W'(1);
          tx_bit_d   = '0;
        end else tx_cnt_d = tx_cnt - DIV_W'(1);
      end
      S_DATA: begin
        tx_line = tx_sh[0];
        if (tx_cnt == '0) begin
          tx_sh_d  = tx_sh >> 1;
          tx_cnt_d = tx_div - DIV_W'(1);
          if (tx_bit == 4'(DATA_BITS - 1)) begin
            tx_bit_d   = '0;
            tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else tx_bit_d = tx_bit + 4'd1;
        end else tx_cnt_d = tx_cnt - DIV_W'(1);
      end
      S_PARITY: begin
        tx_line = tx_par;
        if (tx_cnt == '0) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = tx_div - DIV_W'(1);
          tx_bit_d   = '0;
        end else tx_cnt_d = tx_cnt - DIV_W'(1);
      end
      S_STOP: begin
        if (tx_cnt == '0) begin
          if (tx_bit == 4'(STOP_BITS - 1)) begin
            // chain straight into the next frame when more data is queued
            if (!tx_empty) tx_pop = 1'b1;
            else tx_state_d = S_IDLE;
          end else begin
            tx_bit_d = tx_bit + 4'd1;
            tx_cnt_d = tx_div - DIV_W'(1);
          end
        end else tx_cnt_d = tx_cnt - DIV_W'(1);
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_pop) begin
      tx_state_d = S_START;
      tx_sh_d    = tx_head;
      tx_par_d   = ^tx_head ^ ODD;
      tx_div_d   = div_c;
      tx_cnt_d   = div_c - DIV_W'(1);
      tx_bit_d   = '0;
    end
  end

  // ---------------- receive ----------------
  logic                 rx_m, rx_s, rx_pbit, rx_pbit_d, rx_done, par_ok;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_d, rx_byte, rx_head;
  logic [DIV_W-1:0]     rx_cnt, rx_cnt_d, rx_div, rx_div_d;
  logic [3:0]           rx_bit, rx_bit_d;
  logic                 evt_push, evt_frame, evt_par, evt_ovr, rx_full, rx_empty;
  state_t               rx_state, rx_state_d;

  assign par_ok  = (PARITY == 0) || (rx_pbit == (^rx_sh ^ ODD));
  assign evt_ovr = evt_push && rx_full && !recv_flag;

  uart_port_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .CLK(CLK), .RST(RST), .push(evt_push), .din(rx_byte),
    .pop(recv_flag), .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );
  assign receivable = !rx_empty;
  assign recv_data  = 8'(rx_head);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_state    <= S_IDLE;
      rx_cnt      <= '0;
      rx_div      <= '0;
      rx_bit      <= '0;
      rx_sh       <= '0;
      rx_pbit     <= 1'b0;
      rx_byte     <= '0;
      evt_push    <= 1'b0;
      evt_frame   <= 1'b0;
      evt_par     <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rx_m        <= Rx;
      rx_s        <= rx_m;
      rx_state    <= rx_state_d;
      rx_cnt      <= rx_cnt_d;
      rx_div      <= rx_div_d;
      rx_bit      <= rx_bit_d;
      rx_sh       <= rx_sh_d;
      rx_pbit     <= rx_pbit_d;
      rx_byte     <= rx_sh;
      // stop bit outranks parity, parity outranks overrun
      evt_frame   <= rx_done && !rx_s;
      evt_par     <= rx_done && rx_s && !par_ok;
      evt_push    <= rx_done && rx_s && par_ok;
      err_parity  <= (err_parity  && !err_clear) || evt_par;
      err_frame   <= (err_frame   && !err_clear) || evt_frame;
      err_overrun <= (err_overrun && !err_clear) || evt_ovr;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_div_d   = rx_div;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_pbit_d  = rx_pbit;
    rx_done    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (!rx_s) begin
          rx_state_d = S_START;
          rx_div_d   = div_c;
          rx_cnt_d   = (div_c >> 1) - DIV_W'(1);
        end
      end
      S_START: begin
        if (rx_cnt == '0) begin
          rx_state_d = rx_s ? S_IDLE : S_DATA;
          rx_cnt_d   = rx_div - DIV_W'(1);
          rx_bit_d   = '0;
        end else rx_cnt_d = rx_cnt - DIV_W'(1);
      end
      S_DATA: begin
        if (rx_cnt == '0) begin
          rx_sh_d  = {rx_s, rx_sh[DATA_BITS-1:1]};
          rx_cnt_d = rx_div - DIV_W'(1);
          if (rx_bit == 4'(DATA_BITS - 1)) rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else rx_bit_d = rx_bit + 4'd1;
        end else rx_cnt_d = rx_cnt - DIV_W'(1);
      end
      S_PARITY: begin
        if (rx_cnt == '0) begin
          rx_pbit_d  = rx_s;
          rx_cnt_d   = rx_div - DIV_W'(1);
          rx_state_d = S_STOP;
        end else rx_cnt_d = rx_cnt - DIV_W'(1);
      end
      S_STOP: begin
        if (rx_cnt == '0) begin
          rx_done    = 1'b1;
          rx_state_d = S_IDLE;
        end else rx_cnt_d = rx_cnt - DIV_W'(1);
      end
      default: rx_state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port: an 8E1 instance with a 4-deep FIFO driven from
// the bench, and a 7O2 instance wired Tx->Rx for loopback.
module tb_uart_port;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [15:0] baud_div = 16'd8;
  logic        send_flag = 1'b0, recv_flag = 1'b0, err_clear = 1'b0, rx = 1'b1;
  logic [7:0]  send_data = 8'h00, recv_data;
  logic        sendable, receivable, tx_busy, err_parity, err_frame, err_overrun, tx;

  logic [15:0] baud_div2 = 16'd10;
  logic        send_flag2 = 1'b0, recv_flag2 = 1'b0, err_clear2 = 1'b0;
  logic [7:0]  send_data2 = 8'h00, recv_data2;
  logic        sendable2, receivable2, tx_busy2, err_parity2, err_frame2, err_overrun2, tx2;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  logic [7:0] txq[$];

  uart_port #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_AW(2), .DIV_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .baud_div(baud_div), .send_flag(send_flag), .send_data(send_data),
    .sendable(sendable), .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable),
    .tx_busy(tx_busy), .err_parity(err_parity), .err_frame(err_frame), .err_overrun(err_overrun),
    .err_clear(err_clear), .Tx(tx), .Rx(rx)
  );

  uart_port #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_AW(4), .DIV_W(16)) u_dut2 (
    .CLK(CLK), .RST(RST), .baud_div(baud_div2), .send_flag(send_flag2), .send_data(send_data2),
    .sendable(sendable2), .recv_flag(recv_flag2), .recv_data(recv_data2), .receivable(receivable2),
    .tx_busy(tx_busy2), .err_parity(err_parity2), .err_frame(err_frame2), .err_overrun(err_overrun2),
    .err_clear(err_clear2), .Tx(tx2), .Rx(tx2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 8E1 line level for bit slot k of a frame carrying d
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic push1(input logic [7:0] d);
    send_flag = 1'b1;
    send_data = d;
    @(negedge CLK);
    send_flag = 1'b0;
  endtask

  task automatic push2(input logic [7:0] d);
    send_flag2 = 1'b1;
    send_data2 = d;
    @(negedge CLK);
    send_flag2 = 1'b0;
  endtask

  task automatic wait_tx_start(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(tag, tx, 0);
  endtask

  // Compares every cycle of one frame, starting at its first start-bit cycle.
  task automatic tx_frame_check(input string tag, input int div, input int chg_at, input int new_div);
    logic [7:0] d;
    int bad = 0;
    if (txq.size() == 0) begin
      check({tag, "_queued"}, 0, 1);
      return;
    end
    d = txq.pop_front();
    for (int c = 0; c < 11 * div; c++) begin
      if (tx !== frame_bit(d, c / div) || tx_busy !== 1'b1) bad++;
      if (c == chg_at) baud_div = 16'(new_div);
      @(negedge CLK);
    end
    check(tag, bad, 0);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic par_flip, input logic stop_v, input int div);
    logic [10:0] bits;
    bits = {stop_v, ^d ^ par_flip, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      rx = bits[k];
      repeat (div) @(negedge CLK);
    end
    rx = 1'b1;
    repeat (3 * div) @(negedge CLK);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] d;
    check({tag, "_avail"}, receivable, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_expected"}, 0, 1);
      return;
    end
    d = exp_q.pop_front();
    check(tag, recv_data, d);
    recv_flag = 1'b1;
    @(negedge CLK);
    recv_flag = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n;
    int bad;

    @(negedge CLK);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_sendable", sendable, 1);
    check("rst_receivable", receivable, 0);
    check("rst_recv_data", recv_data, 0);
    check("rst_errs", {err_parity, err_frame, err_overrun}, 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // single 8E1 frame at div 8, including the two-cycle start latency
    txq.push_back(8'hA5);
    send_flag = 1'b1;
    send_data = 8'hA5;
    @(negedge CLK);
    send_flag = 1'b0;
    check("lat_n0_tx", tx, 1);
    @(negedge CLK);
    check("lat_n1_tx", tx, 1);
    @(negedge CLK);
    check("lat_n2_tx", tx, 0);
    tx_frame_check("frame_a5", 8, -1, 0);
    check("a5_end_tx", tx, 1);
    check("a5_end_busy", tx_busy, 0);
    repeat (5) @(negedge CLK);

    // divisor change mid-frame: back-to-back frames at 8 then 16
    txq.push_back(8'h3C);
    txq.push_back(8'hC3);
    push1(8'h3C);
    push1(8'hC3);
    wait_tx_start("baud_start");
    tx_frame_check("frame_div8", 8, 20, 16);
    tx_frame_check("frame_div16", 16, -1, 0);
    check("baud_end_busy", tx_busy, 0);
    repeat (5) @(negedge CLK);

    // Tx FIFO fill, push while full, push+pop on full
    baud_div = 16'd4;
    txq.push_back(8'h11);
    push1(8'h11);
    wait_tx_start("full_start");
    fork
      begin
        for (int k = 0; k < 6; k++) tx_frame_check("frame_fifo", 4, -1, 0);
      end
      begin
        for (int k = 1; k <= 4; k++) begin
          send_flag = 1'b1;
          send_data = 8'(k * 8'h11);
          txq.push_back(8'(k * 8'h11));
          @(negedge CLK);
        end
        check("full_after_4", sendable, 0);
        send_data = 8'h66;
        @(negedge CLK);
        send_flag = 1'b0;
        check("full_ignore", sendable, 0);
        repeat (37) @(negedge CLK);
        send_flag = 1'b1;
        send_data = 8'h77;
        txq.push_back(8'h77);
        @(negedge CLK);
        send_flag = 1'b0;
        check("full_push_pop", sendable, 0);
      end
    join
    check("fifo_end_busy", tx_busy, 0);

    // receive path at div 16
    baud_div = 16'd16;
    exp_q.push_back(8'h96);
    rx_frame(8'h96, 1'b0, 1'b1, 16);
    pop_check("rx_good");
    check("rx_good_empty", receivable, 0);
    check("rx_good_errs", {err_parity, err_frame, err_overrun}, 0);

    rx_frame(8'h3C, 1'b1, 1'b1, 16);
    check("rx_par_errs", {err_parity, err_frame, err_overrun}, 3'b100);
    check("rx_par_nopush", receivable, 0);

    rx_frame(8'h3C, 1'b0, 1'b0, 16);
    check("rx_frm_errs", {err_parity, err_frame, err_overrun}, 3'b110);
    check("rx_frm_nopush", receivable, 0);

    rx = 1'b0;
    repeat (3) @(negedge CLK);
    rx = 1'b1;
    repeat (40) @(negedge CLK);
    check("glitch_nopush", receivable, 0);
    check("glitch_errs", {err_parity, err_frame, err_overrun}, 3'b110);

    err_clear = 1'b1;
    @(negedge CLK);
    err_clear = 1'b0;
    check("err_clear", {err_parity, err_frame, err_overrun}, 0);

    // overrun: five frames into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < 4) exp_q.push_back(d);
      rx_frame(d, 1'b0, 1'b1, 16);
    end
    check("ovr_errs", {err_parity, err_frame, err_overrun}, 3'b001);
    pop_check("ovr_pop0");
    pop_check("ovr_pop1");
    check("ovr_left", receivable, 1);

    // asynchronous reset mid-transmission with full Tx FIFO and pending Rx data
    baud_div = 16'd8;
    for (int i = 0; i < 5; i++) push1(8'(8'hF0 + i));
    repeat (30) @(negedge CLK);
    check("pre_rst_busy", tx_busy, 1);
    check("pre_rst_sendable", sendable, 0);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_sendable", sendable, 1);
    check("mid_rst_receivable", receivable, 0);
    check("mid_rst_recv_data", recv_data, 0);
    check("mid_rst_errs", {err_parity, err_frame, err_overrun}, 0);
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    txq.delete();
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      @(negedge CLK);
    end
    check("rst_fifo_discard", bad, 0);

    // loopback on the 7O2 instance at div 10
    exp2_q.push_back(8'h00);
    push2(8'h00);
    n = 0;
    while (tx2 !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("lb_start", tx2, 0);
    push2(8'h7F);
    push2(8'h55);
    push2(8'hFF);
    exp2_q.push_back(8'h7F);
    exp2_q.push_back(8'h55);
    exp2_q.push_back(8'h7F);
    repeat (72) @(negedge CLK);
    check("lb_bit6", tx2, 0);
    repeat (10) @(negedge CLK);
    check("lb_odd_parity", tx2, 1);
    repeat (10) @(negedge CLK);
    check("lb_stop1", tx2, 1);
    repeat (10) @(negedge CLK);
    check("lb_stop2", tx2, 1);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (receivable2 !== 1'b1 && n < 600) begin
        @(negedge CLK);
        n++;
      end
      check("lb_avail", receivable2, 1);
      d = (exp2_q.size() != 0) ? exp2_q.pop_front() : 8'hXX;
      check("lb_data", recv_data2, d);
      recv_flag2 = 1'b1;
      @(negedge CLK);
      recv_flag2 = 1'b0;
    end
    repeat (5) @(negedge CLK);
    check("lb_empty", receivable2, 0);
    check("lb_errs", {err_parity2, err_frame2, err_overrun2}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_port.md
# uart_port

Parametrised full-duplex UART endpoint; successor to the fixed 8-bit / even-parity / fixed-baud UART link block. It adds configurable frame format, a runtime baud divisor, configurable FIFO depth, 2-flop Rx synchronisation and sticky error reporting. It sits between the CPU memory-mapped I/O controller (byte FIFO handshake) and the board Tx/Rx pins.

## Interface
- DATA_BITS, 8: data bits per frame, 5..8, sent LSB first.
- PARITY, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2; Tx sends all of them, Rx checks only the first.
- FIFO_AW, 4: address width of the Tx and Rx FIFOs; depth is 2^FIFO_AW.
- DIV_W, 16: width of baud_div.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- baud_div  in  DIV_W  clocks per bit; values below 4 are treated as 4; sampled at each frame start.
- send_flag  in  1  push send_data into the Tx FIFO.
- send_data  in  8  byte to send; bits above DATA_BITS are ignored.
- sendable  out  1  Tx FIFO not full.
- recv_flag  in  1  pop the Rx FIFO.
- recv_data  out  8  Rx FIFO head (first-word fall-through); bits above DATA_BITS read 0.
- receivable  out  1  Rx FIFO not empty.
- tx_busy  out  1  high from the start bit through the last stop bit.
- err_parity, err_frame, err_overrun  out  1 each  sticky error flags.
- err_clear  in  1  clears all three error flags.
- Tx  out  1  serial out; idles high.
- Rx  in  1  serial in; asynchronous.

## Operation
- FIFOs (2^FIFO_AW entries, wrapping pointers plus one extra bit for full/empty):
  - Push while full is ignored.
  - Pop while empty is ignored.
  - Simultaneous push and pop is legal in every state, including full and empty.
- Tx FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START when the Tx FIFO is non-empty: pop the head, latch it into a shift register, load the bit counter from baud_div.
  - START to DATA after one bit period.
  - DATA lasts DATA_BITS periods, then goes to PARITY, or to STOP when PARITY=0.
  - Parity bit is the XOR of the data bits (even), inverted for odd.
  - STOP drives 1 for STOP_BITS periods, then returns to IDLE.
  - Back-to-back frames have no extra idle gap.
- Rx front end: Rx passes through a 2-flop synchroniser; the result is rx_s.
- Rx FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s==0 moves to START and loads baud_div (clamped) into the divisor latch.
  - START: sample at floor(div/2) cycles after detection. If rx_s==1 (glitch), return to IDLE with no error.
  - DATA and PARITY: one sample every div cycles after the start sample.
  - STOP: sample once.
- Rx stop-bit sample resolution, in priority order:
  1. stop bit == 0: set err_frame, discard the byte.
  2. Parity mismatch: set err_parity, discard the byte.
  3. Rx FIFO full: set err_overrun, discard the byte.
  4. Otherwise push the byte into the Rx FIFO.
- After the stop sample, Rx returns to IDLE immediately (mid stop bit), so a following start bit is caught.
- Error flags: an error event and err_clear in the same cycle leaves the flag set.
- Changing baud_div mid-frame does not affect the frame in flight.
- Reset (async, at any time, including mid-frame):
  - Tx=1, tx_busy=0.
  - Both FIFOs emptied: sendable=1, receivable=0, recv_data=0.
  - Error flags 0, both FSMs to IDLE, counters 0.
  - A partial Rx frame is lost. A Tx frame is cut off; the receiver sees a frame error or a glitch.

## Timing
- send_flag at edge n with the FSM idle: sendable reflects the push after edge n. Tx falls at edge n+2 (FIFO write, then FSM pop).
- Each Tx bit lasts exactly div cycles. Frame length is div × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS).
- Rx: the byte becomes visible (receivable=1, recv_data valid) one cycle after the stop-bit sample edge.
  - The stop-bit sample edge is about 2 (synchroniser) + floor(div/2) + div × (DATA_BITS + (PARITY≠0) + 1) cycles after the Rx falling edge.
- recv_flag at edge n: recv_data shows the next entry after edge n.
- Error flags rise one cycle after the stop sample.

## Test plan
- Reset value check: assert RST mid-transmission -> Tx=1, tx_busy=0, sendable=1, receivable=0, recv_data=0 and all error flags 0 immediately. Tx FIFO contents are discarded.
- Tx format (div=8, 8E1): push 0xA5 -> Tx = start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit exactly 8 cycles, 88 cycles total. Repeat with PARITY=2: parity bit = 1.
- Loopback (Tx→Rx, div=10, DATA_BITS=7, STOP_BITS=2): push 0x00, 0x7F, 0x55, 0xFF -> recv_data pops 0x00, 0x7F, 0x55, 0x7F in order, with no errors.
- Rx errors (div=16): inject frame 0x3C with a wrong parity bit -> err_parity=1, no push. Inject 0x3C with stop=0 -> err_frame=1. Inject a 3-cycle low glitch -> no push, no error. err_clear -> all flags 0.
- Overrun (FIFO_AW=2): receive 5 frames without recv_flag -> first 4 bytes held, err_overrun=1 after the 5th. Push 5 bytes to Tx -> sendable=0 after the 4th push, and the 5th push is ignored.
- Simultaneous push and pop on a full FIFO -> occupancy unchanged and order preserved. Change baud_div from 8 to 16 mid-frame -> the current frame stays at 8 cycles per bit and the next frame uses 16.
